edge_event_arbiter: RTL
=======================

# edge_event_arbiter

Synchronises up to N asynchronous level inputs and detects a rising edge on each one. Each detected edge is latched as a pending event per channel. Pending events are granted one at a time through a registered valid/ready port, using round-robin order. The block sits between raw inputs (buttons, external strobes, status lines) and a single consumer FSM, so many edge sources share one event path without losing or duplicating events.

## Interface
- N_CHANNELS, default 4: number of input channels; legal range 2..16.
- SYNC_STAGES, default 2: synchroniser depth per channel; legal range 2..4.
- ID_W, default $clog2(N_CHANNELS): width of event_id_out. Derived; do not override.

- clk_in  input  1  system clock; every flop is on its rising edge.
- rst_in  input  1  reset, asynchronous and active-high.
- level_in  input  N_CHANNELS  raw asynchronous levels, one per channel.
- enable_in  input  N_CHANNELS  per-channel capture enable; gates new edges only.
- event_valid_out  output  1  an event is offered.
- event_ready_in  input  1  consumer accepts the offered event.
- event_id_out  output  ID_W  channel index of the offered event.
- pending_out  output  N_CHANNELS  pending flags, not yet loaded into the output slot.
- overflow_out  output  N_CHANNELS  sticky flag: an edge arrived while that channel was already pending.
- clear_overflow_in  input  1  single-cycle pulse that clears all overflow bits.

## Operation
- Synchroniser: a SYNC_STAGES flop chain per channel; all stages reset to 0.
- Edge detect: a prev register per channel, reset to 0.
  - rise[c] = sync_last[c] & ~prev[c].
  - A level that is already high when reset releases produces exactly one edge.
- Pending set: on rise[c] & enable_in[c], pending[c] <= 1.
  - If pending[c] is already 1 and is not being loaded this cycle, overflow[c] <= 1.
  - The new edge merges into the existing pending event; one event is lost.
- Edges on disabled channels are dropped and never set overflow.
- Deasserting enable_in does not clear existing pending bits.
- Output slot states:
  - IDLE: event_valid_out=0.
  - OFFER: event_valid_out=1 and event_id_out=slot.
- IDLE -> OFFER when any pending bit is set:
  - Slot <= arbitration winner; pending[winner] cleared on the same edge.
- OFFER with event_ready_in=1 (handshake):
  - rr_ptr <= (slot+1) mod N_CHANNELS.
  - If another pending bit exists, load the next winner on the same edge and stay in OFFER. This gives back-to-back events at one per cycle.
  - Otherwise go to IDLE.
- OFFER with event_ready_in=0: hold. event_id_out and event_valid_out stay stable until the handshake.
- Arbitration: the winner is the lowest channel index >= rr_ptr with pending set, wrapping to 0. rr_ptr resets to 0.
  - For the back-to-back load, the search starts from the updated pointer (slot+1).
- Simultaneous events:
  - Rise on channel c in the cycle pending[c] is loaded: pending[c] stays 1 and no overflow is flagged. One event is in the slot and one is pending.
  - rise & clear_overflow_in on the same bit: the set wins (overflow[c] = 1).
- Reset mid-operation: everything clears asynchronously, event_valid_out drops immediately, and the in-flight event is discarded.

## Timing
- Reset values:
  - event_valid_out=0, event_id_out=0, pending_out=0, overflow_out=0.
  - rr_ptr=0, sync stages=0, prev=0.
- Latency: level_in is first sampled high at edge k.
  - pending set at edge k+SYNC_STAGES.
  - event_valid_out high after edge k+SYNC_STAGES+1.
  - Default: 3 cycles.
- A level must be stable for at least 1 cycle to be detected. A level held high produces one event only; a new event requires low for at least 1 cycle, then high again.
- All outputs are registered; there is no combinational path from any input to any output.
- Throughput: 1 event per cycle when event_ready_in is held high.

## Test plan
- Reset/latency:
  - Stimulus: assert rst_in mid-cycle while OFFER is active.
  - Required response: event_valid_out falls before the next edge and all outputs read 0.
  - Stimulus: after release, raise level_in[2] at cycle 0 with default parameters and ready=1.
  - Required response: valid=1 with id=2 at cycle 3, for exactly one cycle; pending_out=0 afterwards.
- Round-robin:
  - Stimulus: rise channels 0,1,3 in the same cycle with ready=1.
  - Required response: ids 0,1,3 on consecutive cycles.
  - Stimulus: then rise 0 and 3 together.
  - Required response: 0 first, then 3 (rr_ptr=0 after grant 3 wraps).
- Backpressure:
  - Stimulus: hold ready=0 for 10 cycles with channel 1 offered.
  - Required response: id stays 1 and valid stays 1.
  - Stimulus: a second rise on channel 1 during the stall.
  - Required response: pending_out[1]=1, no overflow; after ready=1, two id=1 events.
- Overflow:
  - Stimulus: with the slot stalled on channel 0, produce three separate rises on channel 1.
  - Required response: overflow_out[1]=1 after the 2nd; exactly one channel-1 event delivered after the stall.
  - Stimulus: pulse clear_overflow_in.
  - Required response: overflow_out=0.
  - Stimulus: a clear coinciding with a new overflow.
  - Required response: the bit remains 1.
- Enable/held level:
  - Stimulus: enable_in[2]=0 while channel 2 toggles.
  - Required response: no events and no overflow.
  - Stimulus: hold level_in[0] high for 50 cycles.
  - Required response: exactly one event.
  - Stimulus: level_in[3] high before reset release.
  - Required response: one event after release.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Synchronises N asynchronous level inputs, latches each rising edge as a pending event,
// and hands the events one at a time to a single consumer through a round-robin valid/ready slot.
module edge_event_arbiter #(
    parameter int N_CHANNELS  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = $clog2(N_CHANNELS)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [N_CHANNELS-1:0] level_in,
    input  logic [N_CHANNELS-1:0] enable_in,
    output logic                  event_valid_out,
    input  logic                  event_ready_in,
    output logic [ID_W-1:0]       event_id_out,
    output logic [N_CHANNELS-1:0] pending_out,
    output logic [N_CHANNELS-1:0] overflow_out,
    input  logic                  clear_overflow_in
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    logic [N_CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [N_CHANNELS-1:0] prev_q;
    logic [N_CHANNELS-1:0] rise;
    logic [N_CHANNELS-1:0] capture;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       slot_q, slot_d;
    logic [ID_W-1:0]       rr_q, rr_d;
    logic [N_CHANNELS-1:0] pending_q, pending_d;
    logic [N_CHANNELS-1:0] overflow_q, overflow_d;

    logic                  load;
    logic [ID_W-1:0]       load_idx;
    logic [N_CHANNELS-1:0] load_mask;

    // First set bit of req at or after start, wrapping past the top channel to 0.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_CHANNELS-1:0] req,
                                                input logic [ID_W-1:0]       start);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            idx = int'(start) + i;
            if (idx >= N_CHANNELS) idx = idx - N_CHANNELS;
            if (!found && req[idx]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        return (v == ID_W'(N_CHANNELS - 1)) ? '0 : v + 1'b1;
    endfunction

    // NOTE: the sync chain is an array of flops, not RAM, so every stage is reset; that is
    // what makes a level already high at reset release look like exactly one fresh edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old value of its
            // predecessor, so the chain really delays by one cycle per stage.
            sync_q[0] <= level_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign capture = rise & enable_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            rr_q       <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            rr_q       <= rr_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d    = state_q;
        slot_d     = slot_q;
        rr_d       = rr_q;
        load       = 1'b0;
        load_idx   = '0;
        load_mask  = '0;
        pending_d  = pending_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    load     = 1'b1;
                    load_idx = rr_pick(pending_q, rr_q);
                    state_d  = OFFER;
                end
            end
            OFFER: begin
                if (event_ready_in) begin
                    rr_d = wrap_inc(slot_q);
                    if (|pending_q) begin
                        load     = 1'b1;
                        load_idx = rr_pick(pending_q, rr_d);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            slot_d    = load_idx;
            load_mask = N_CHANNELS'(1) << load_idx;
        end

        // A channel being moved into the slot this cycle has room for one more event,
        // so only a capture on a pending, non-loaded channel counts as lost.
        pending_d  = (pending_q & ~load_mask) | capture;
        overflow_d = (clear_overflow_in ? '0 : overflow_q) | (capture & pending_q & ~load_mask);
    end

    assign event_valid_out = (state_q == OFFER);
    assign event_id_out    = slot_q;
    assign pending_out     = pending_q;
    assign overflow_out    = overflow_q;

endmodule
